// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronizes rx, finds the start bit on the oversampling
// tick and returns one character per frame with parity/framing/break status.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line idle, waiting for a falling edge on the synchronized rx
// ST_START  | qualifying the start bit at its mid point
// ST_DATA   | sampling 5-8 data bits LSB-first
// ST_PAR    | sampling the parity bit
// ST_STOP   | sampling the stop bit and publishing the character
// ST_RESYNC | stop bit was low, waiting for the line to return high
module uart_rx_deframer #(
   parameter int NrSyncStages   = 2,
   parameter int OversampleRate = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   input  logic       baud_tick_i,
   input  logic [1:0] word_len_i,
   input  logic       par_en_i,
   input  logic       even_par_i,
   input  logic       force_par_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       par_err_o,
   output logic       frame_err_o,
   output logic       break_o,
   output logic       busy_o
);

   localparam int CntW = $clog2(OversampleRate);
   localparam logic [CntW-1:0] CntMid  = CntW'(OversampleRate / 2 - 1);
   localparam logic [CntW-1:0] CntWrap = CntW'(OversampleRate - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP,
      ST_RESYNC
   } state_t;

   logic [NrSyncStages-1:0] r_sync;
   logic                    r_prev;
   state_t                  r_state;
   logic [CntW-1:0]         r_cnt;
   logic [2:0]              r_bitcnt;
   logic [7:0]              r_shift;
   logic                    r_par_bit;
   logic                    r_par_err;
   logic [1:0]              r_cfg_wl;
   logic                    r_cfg_par_en;
   logic                    r_cfg_even;
   logic                    r_cfg_force;
   logic [7:0]              r_data;
   logic                    r_valid;
   logic                    r_par_err_o;
   logic                    r_frame_err;
   logic                    r_break;
   logic                    r_busy;

   logic w_rxs;
   logic w_fall;
   logic w_last_bit;
   logic w_exp_par;

   assign w_rxs      = r_sync[NrSyncStages-1];
   assign w_fall     = ~w_rxs & r_prev;
   assign w_last_bit = (r_bitcnt == ({1'b0, r_cfg_wl} + 3'd4));
   // unused upper bits of r_shift are zero, so reducing all 8 bits is safe
   assign w_exp_par  = r_cfg_force ? ~r_cfg_even
                                   : (r_cfg_even ? ^r_shift : ~^r_shift);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[NrSyncStages-2:0], rx_i};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_prev       <= 1'b1;
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_bitcnt     <= '0;
         r_shift      <= '0;
         r_par_bit    <= 1'b0;
         r_par_err    <= 1'b0;
         r_cfg_wl     <= '0;
         r_cfg_par_en <= 1'b0;
         r_cfg_even   <= 1'b0;
         r_cfg_force  <= 1'b0;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_par_err_o  <= 1'b0;
         r_frame_err  <= 1'b0;
         r_break      <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_prev  <= w_rxs;
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_fall) begin
                  r_state      <= ST_START;
                  r_cnt        <= '0;
                  r_busy       <= 1'b1;
                  r_cfg_wl     <= word_len_i;
                  r_cfg_par_en <= par_en_i;
                  r_cfg_even   <= even_par_i;
                  r_cfg_force  <= force_par_i;
               end
            end
            ST_START: begin
               if (baud_tick_i) begin
                  if (r_cnt == CntMid) begin
                     r_cnt <= '0;
                     if (w_rxs) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state   <= ST_DATA;
                        r_bitcnt  <= '0;
                        r_shift   <= '0;
                        r_par_bit <= 1'b0;
                        r_par_err <= 1'b0;
                     end
                  end else begin
                     r_cnt <= r_cnt + CntW'(1);
                  end
               end
            end
            ST_DATA: begin
               if (baud_tick_i) begin
                  r_cnt <= r_cnt + CntW'(1);
                  if (r_cnt == CntWrap) begin
                     r_shift[r_bitcnt] <= w_rxs;
                     r_bitcnt          <= r_bitcnt + 3'd1;
                     if (w_last_bit) begin
                        r_state <= r_cfg_par_en ? ST_PAR : ST_STOP;
                     end
                  end
               end
            end
            ST_PAR: begin
               if (baud_tick_i) begin
                  r_cnt <= r_cnt + CntW'(1);
                  if (r_cnt == CntWrap) begin
                     r_par_bit <= w_rxs;
                     r_par_err <= (w_rxs != w_exp_par);
                     r_state   <= ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               if (baud_tick_i) begin
                  r_cnt <= r_cnt + CntW'(1);
                  if (r_cnt == CntWrap) begin
                     r_valid     <= 1'b1;
                     r_data      <= r_shift;
                     r_par_err_o <= r_par_err;
                     r_frame_err <= ~w_rxs;
                     r_break     <= (r_shift == 8'd0) && !(r_cfg_par_en && r_par_bit) && !w_rxs;
                     r_state     <= w_rxs ? ST_IDLE : ST_RESYNC;
                     r_busy      <= ~w_rxs;
                  end
               end
            end
            ST_RESYNC: begin
               if (w_rxs) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign data_o      = r_data;
   assign valid_o     = r_valid;
   assign par_err_o   = r_par_err_o;
   assign frame_err_o = r_frame_err;
   assign break_o     = r_break;
   assign busy_o      = r_busy;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: baud tick every 4 clocks (64 clocks per bit),
// frames driven bit by bit with hand-computed expected characters and flags.
module tb_uart_rx_deframer;

   localparam int BitClks = 64;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       rx_i;
   logic       baud_tick_i;
   logic [1:0] word_len_i;
   logic       par_en_i;
   logic       even_par_i;
   logic       force_par_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       par_err_o;
   logic       frame_err_o;
   logic       break_o;
   logic       busy_o;

   int ntests = 0;
   int nfail  = 0;
   int vcnt   = 0;
   int tcnt   = 0;

   uart_rx_deframer #(
      .NrSyncStages  (2),
      .OversampleRate(16)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rx_i       (rx_i),
      .baud_tick_i(baud_tick_i),
      .word_len_i (word_len_i),
      .par_en_i   (par_en_i),
      .even_par_i (even_par_i),
      .force_par_i(force_par_i),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .par_err_o  (par_err_o),
      .frame_err_o(frame_err_o),
      .break_o    (break_o),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      baud_tick_i = 1'b0;
      forever begin
         @(negedge clk_i);
         tcnt++;
         baud_tick_i = (tcnt % 4 == 0);
      end
   end

   // valid_o lasts one clock, so each pulse is seen on exactly one falling edge
   initial begin
      forever begin
         @(negedge clk_i);
         if (valid_o === 1'b1) vcnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      rx_i = b;
      repeat (BitClks) @(negedge clk_i);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nbits, input logic has_par,
                             input logic p, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(d[i]);
      if (has_par) drive_bit(p);
      drive_bit(stop);
      rx_i = 1'b1;
      repeat (BitClks) @(negedge clk_i);
   endtask

   task automatic set_cfg(input logic [1:0] wl, input logic pe, input logic ev, input logic fp);
      word_len_i  = wl;
      par_en_i    = pe;
      even_par_i  = ev;
      force_par_i = fp;
   endtask

   initial begin
      rst_i = 1'b1;
      rx_i  = 1'b1;
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk_i);
      check("rst_data", data_o, 8'h00);
      check("rst_valid", valid_o, 1'b0);
      check("rst_flags", {par_err_o, frame_err_o, break_o}, 3'b000);
      check("rst_busy", busy_o, 1'b0);
      rst_i = 1'b0;
      repeat (BitClks) @(negedge clk_i);
      check("idle_vcnt", vcnt, 0);

      // 8N1 0xA5
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
      check("a5_vcnt", vcnt, 1);
      check("a5_data", data_o, 8'hA5);
      check("a5_flags", {par_err_o, frame_err_o, break_o}, 3'b000);
      check("a5_busy", busy_o, 1'b0);

      // 7E1 0x35: four ones, so even parity bit is 0
      set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
      send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1);
      check("e35_vcnt", vcnt, 2);
      check("e35_data", data_o, 8'h35);
      check("e35_perr", par_err_o, 1'b0);
      send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1);
      check("e35b_vcnt", vcnt, 3);
      check("e35b_perr", par_err_o, 1'b1);

      // 5N1 0x1F; config changes during the frame must be ignored
      set_cfg(2'b00, 1'b0, 1'b0, 1'b0);
      fork
         send_frame(8'hFF, 5, 1'b0, 1'b0, 1'b1);
         begin
            repeat (BitClks * 2) @(negedge clk_i);
            set_cfg(2'b11, 1'b1, 1'b0, 1'b0);
         end
      join
      check("w5_vcnt", vcnt, 4);
      check("w5_data", data_o, 8'h1F);
      check("w5_perr", par_err_o, 1'b0);

      // stick parity, even_par=1 -> expected parity bit 0
      set_cfg(2'b11, 1'b1, 1'b1, 1'b1);
      send_frame(8'h00, 8, 1'b1, 1'b0, 1'b1);
      check("stk0_vcnt", vcnt, 5);
      check("stk0_perr", par_err_o, 1'b0);
      check("stk0_brk", break_o, 1'b0);
      send_frame(8'h00, 8, 1'b1, 1'b1, 1'b1);
      check("stk1_vcnt", vcnt, 6);
      check("stk1_perr", par_err_o, 1'b1);

      // glitch: low for 4 ticks only
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      rx_i = 1'b0;
      repeat (16) @(negedge clk_i);
      check("gl_busy_hi", busy_o, 1'b1);
      rx_i = 1'b1;
      repeat (32) @(negedge clk_i);
      check("gl_busy_lo", busy_o, 1'b0);
      repeat (BitClks) @(negedge clk_i);
      check("gl_vcnt", vcnt, 6);

      // framing error then clean frame
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0);
      check("fe_vcnt", vcnt, 7);
      check("fe_data", data_o, 8'h55);
      check("fe_flags", {par_err_o, frame_err_o, break_o}, 3'b010);
      check("fe_busy", busy_o, 1'b0);
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
      check("c3_vcnt", vcnt, 8);
      check("c3_data", data_o, 8'h3C);
      check("c3_flags", {par_err_o, frame_err_o, break_o}, 3'b000);

      // break: line low for 30 bit times
      rx_i = 1'b0;
      repeat (BitClks * 30) @(negedge clk_i);
      check("brk_vcnt", vcnt, 9);
      check("brk_data", data_o, 8'h00);
      check("brk_flags", {par_err_o, frame_err_o, break_o}, 3'b011);
      check("brk_busy", busy_o, 1'b1);
      rx_i = 1'b1;
      repeat (BitClks) @(negedge clk_i);
      check("brk_busy_lo", busy_o, 1'b0);
      check("brk_vcnt2", vcnt, 9);

      // reset in the middle of DATA
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      #3;
      rst_i = 1'b1;
      #1;
      check("mid_rst_busy", busy_o, 1'b0);
      check("mid_rst_flags", {par_err_o, frame_err_o, break_o}, 3'b000);
      check("mid_rst_data", data_o, 8'h00);
      rx_i = 1'b1;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (BitClks) @(negedge clk_i);
      send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
      check("r81_vcnt", vcnt, 10);
      check("r81_data", data_o, 8'h81);
      check("r81_flags", {par_err_o, frame_err_o, break_o}, 3'b000);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side serial deframer of the UART, feeding the RX FIFO / receive holding register path.
- Synchronizes the asynchronous rx line and detects start bits using a 16x oversampling tick from the baud generator.
- Shifts in 5-8 data bits LSB-first, checks parity and stop bit, then emits one character per frame with parity/framing/break status.
- Line configuration comes from the line control register fields.

Parameters:
NrSyncStages  2   number of flip-flops in the rx input synchronizer (>=2)
OversampleRate  16   baud ticks per bit period; must be a power of two, >=4

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous, active-high reset
rx_i  input  1  asynchronous serial input, idle high
baud_tick_i  input  1  single-cycle pulse, OversampleRate per bit period
word_len_i  input  2  2'b00:5, 01:6, 10:7, 11:8 data bits
par_en_i  input  1  parity bit present
even_par_i  input  1  1 = even parity, 0 = odd parity
force_par_i  input  1  stick parity enable
data_o  output  8  received character, right-aligned, unused MSBs 0
valid_o  output  1  one-cycle pulse: data_o and flags are new
par_err_o  output  1  parity mismatch for the character on data_o
frame_err_o  output  1  stop bit sampled 0
break_o  output  1  data, parity and stop bits all sampled 0
busy_o  output  1  state != IDLE

Behaviour:
- Interface: one clock clk_i; reset rst_i is asynchronous, active-high.
- Reset values:
  - Synchronizer flops and the previous-sample flop reset to 1.
  - State resets to IDLE; all counters reset to 0.
  - data_o=0; valid_o, par_err_o, frame_err_o, break_o, busy_o = 0.
- Synchronization: rx_i passes through NrSyncStages flops; all logic uses the last stage (rxs).
- Tick counter and sampling:
  - A log2(OversampleRate)-bit tick counter advances only on baud_tick_i; no other state changes occur on ticks except as listed.
  - Mid-bit sample point = counter reaching OversampleRate/2-1 in START, and counter wrap (OversampleRate-1) in later states.
- States:
  - IDLE: rxs==0 and prev sample==1 (falling edge) -> START, counter cleared.
    - Latch word_len_i, par_en_i, even_par_i, force_par_i into frame config.
    - Config changes mid-frame are ignored.
  - START: at the mid sample, rxs==1 -> IDLE (glitch rejected, no output); rxs==0 -> DATA, counter cleared, bit counter cleared.
  - DATA: at each wrap, shift rxs into the data register LSB-first and increment the bit counter.
    - After 5+word_len bits: -> PAR if par_en, else -> STOP.
  - PAR: at wrap, sample parity bit p.
    - force_par=1: expected parity = ~even_par (stick).
    - force_par=0: expected = ^data for even, ~^data for odd.
    - par_err = (p != expected); -> STOP.
  - STOP: at wrap, sample the stop bit (only one checked regardless of the configured stop-bit count).
    - Assert valid_o for exactly one clock.
    - Update data_o (MSBs above word length zeroed), par_err_o, frame_err_o = ~stop.
    - break_o = all data bits, parity (if enabled) and stop == 0.
    - Then: stop==1 -> IDLE; stop==0 -> RESYNC.
  - RESYNC: wait until rxs==1, then -> IDLE. A held-low line never generates a second frame.
- Output holding: data_o and the three flags hold their values until the next valid_o; flags are never cleared independently.
- Reset mid-frame: immediate return to IDLE and reset values; the partial character is discarded.
- Line low at reset release: the previous-sample flop = 1, so this is treated as a falling edge and a frame starts. If the line stays low, this yields a break character, then RESYNC.
- Boundary cases:
  - baud_tick_i on the same cycle as the falling edge is not counted.
  - baud_tick_i on consecutive cycles is legal.
- Latency: valid_o rises 1 clock after the stop-bit sample tick.

Test Plan:
- 8N1, baud_tick_i every 4 clocks, send 0xA5 -> exactly one valid_o pulse; data_o=0xA5, par_err_o=0, frame_err_o=0, break_o=0; busy_o low afterwards.
- 7E1, send 0x35 with parity bit 0 -> data_o=0x35, par_err_o=0. Resend with parity bit 1 -> par_err_o=1. Then 5N1 0x1F -> data_o=0x1F with bits 7:5 = 0.
- Stick parity: force_par=1, even_par=1, 8 bits 0x00 with parity 0 -> par_err_o=0; same with parity 1 -> par_err_o=1.
- Glitch: rx low for 4 ticks, then high -> no valid_o; busy_o returns low by tick 8.
- Framing: 8N1 0x55 with stop bit 0, then line high -> data_o=0x55, frame_err_o=1, break_o=0. Next good frame 0x3C decodes cleanly.
- Break and reset:
  - Line held low for 30 bit times -> exactly one valid_o with data_o=0x00, frame_err_o=1, break_o=1; no further valid_o until the line returns high and a new start arrives.
  - Assert rst_i mid-DATA -> all outputs 0 asynchronously; next frame 0x81 is received correctly.
